// File: rtl/image_writer_if.sv
// rtl/image_writer_if.sv - Avalon-MM register/buffer port plus pixel output stream of image_writer.
interface image_writer_if;
    logic [6:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        pix_last;

    modport master (
        output addr, rd_en, wr_en, writedata, pix_ready,
        input  readdata, pix_valid, pix_data, pix_x, pix_y, pix_last
    );

    modport slave (
        input  addr, rd_en, wr_en, writedata, pix_ready,
        output readdata, pix_valid, pix_data, pix_x, pix_y, pix_last
    );
endinterface

// File: rtl/image_writer.sv
// rtl/image_writer.sv - 8x8 block buffer streamed as screen-positioned pixels.
module image_writer #(
    parameter int X_ORIGIN  = 208,
    parameter int Y_ORIGIN  = 128,
    parameter int MAX_INDEX = 27
) (
    input  logic          clk,
    input  logic          reset,
    image_writer_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [5:0] k, k_nxt;
    logic [7:0] mcu, mcu_nxt;
    logic [7:0] strip, strip_nxt;
    logic       done, done_nxt;
    logic       error, error_nxt;
    logic [7:0] buffer [64];

    logic       ctrl_wr, buf_wr, start_req, range_ok, fire;
    logic [7:0] req_mcu, req_strip;

    assign ctrl_wr   = bus.wr_en && (bus.addr == 7'd64);
    assign buf_wr    = bus.wr_en && !bus.addr[6];
    assign req_mcu   = bus.writedata[7:0];
    assign req_strip = bus.writedata[15:8];
    assign start_req = ctrl_wr && bus.writedata[16];
    assign range_ok  = ({24'd0, req_mcu} <= 32'(MAX_INDEX)) &&
                       ({24'd0, req_strip} <= 32'(MAX_INDEX));
    assign fire      = (state == STREAM) && bus.pix_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= 6'd0;
            mcu   <= 8'd0;
            strip <= 8'd0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            mcu   <= mcu_nxt;
            strip <= strip_nxt;
            done  <= done_nxt;
            error <= error_nxt;
        end
    end

    // Buffer is frozen while streaming so pix_data stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (!reset && buf_wr && (state == IDLE)) begin
            buffer[bus.addr[5:0]] <= bus.writedata[7:0];
        end
    end

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        mcu_nxt       = mcu;
        strip_nxt     = strip;
        done_nxt      = done;
        error_nxt     = error;
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        bus.pix_data  = 8'd0;
        bus.pix_x     = 11'd0;
        bus.pix_y     = 11'd0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    if (range_ok) begin
                        state_nxt = STREAM;
                        k_nxt     = 6'd0;
                        mcu_nxt   = req_mcu;
                        strip_nxt = req_strip;
                        done_nxt  = 1'b0;
                        error_nxt = 1'b0;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end
            STREAM: begin
                bus.pix_valid = 1'b1;
                bus.pix_last  = (k == 6'd63);
                bus.pix_data  = buffer[k];
                bus.pix_x     = 11'(X_ORIGIN) + {mcu, 3'b000} + {8'd0, k[2:0]};
                bus.pix_y     = 11'(Y_ORIGIN) + {strip, 3'b000} + {8'd0, k[5:3]};
                if (ctrl_wr || buf_wr) begin
                    error_nxt = 1'b1;
                end
                if (fire) begin
                    k_nxt = k + 6'd1;
                    if (k == 6'd63) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.readdata = 32'd0;
        if (bus.rd_en) begin
            if (!bus.addr[6]) begin
                bus.readdata = {24'd0, buffer[bus.addr[5:0]]};
            end else if (bus.addr == 7'd64) begin
                bus.readdata = {16'd0, strip, mcu};
            end else if (bus.addr == 7'd65) begin
                bus.readdata = {29'd0, error, done, state == STREAM};
            end
        end
    end
endmodule
